// File: rtl/eth_frame_tx_if.sv
// Byte-stream handshakes around the Ethernet frame transmitter:
// payload in from the protocol side, frame bytes out to the MAC.
interface eth_frame_tx_if;
   logic [7:0] i_wdata;
   logic       i_wvalid;
   logic       o_wready;
   logic [7:0] o_tdata;
   logic       o_tvalid;
   logic       i_tready;
   logic       o_tlast;

   modport master (
      output i_wdata, i_wvalid, i_tready,
      input  o_wready, o_tdata, o_tvalid, o_tlast
   );

   modport slave (
      input  i_wdata, i_wvalid, i_tready,
      output o_wready, o_tdata, o_tvalid, o_tlast
   );
endinterface

// File: rtl/eth_frame_tx.sv
// Store-and-forward Ethernet II framer: buffers a payload burst,
// then sends header, payload and zero pad up to the 60-byte minimum.
module eth_frame_tx #(
   parameter logic [47:0] DST_MAC      = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_MAC      = 48'h02_00_00_00_00_01,
   parameter logic [15:0] ETYPE_RAW    = 16'h88B5,
   parameter logic [15:0] ETYPE_MHP    = 16'h88B6,
   parameter int          BUF_DEPTH    = 64,
   parameter int          IDLE_TIMEOUT = 16
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_link,
   eth_frame_tx_if.slave  bus,
   output logic           o_busy,
   output logic           o_frame_sent
);

   localparam int AW   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW   = $clog2(BUF_DEPTH + 1);
   localparam int FMAX = (14 + BUF_DEPTH > 60) ? 14 + BUF_DEPTH : 60;
   localparam int IW   = $clog2(FMAX + 1);

   typedef enum logic [1:0] {
      FILL,
      HDR,
      PAYLOAD,
      PAD
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            en;
   logic [CW-1:0]   count;
   logic [7:0]      timer;
   logic [IW-1:0]   idx;
   logic            etype_sel;
   logic            sent;
   logic [7:0]      mem [BUF_DEPTH];

   logic            acc;
   logic            hs;
   logic            close;
   logic            last;
   logic [IW-1:0]   cnt_x;
   logic [IW-1:0]   len;
   logic [111:0]    hdr;
   logic [3:0]      hsel;
   logic [AW-1:0]   rd;

   assign acc   = bus.i_wvalid & bus.o_wready;
   assign hs    = bus.o_tvalid & bus.i_tready;
   assign cnt_x = IW'(count);
   // Short payloads are padded so header+payload+pad is 60 bytes.
   assign len   = (cnt_x >= IW'(46)) ? cnt_x + IW'(14) : IW'(60);
   assign last  = (idx == len - IW'(1));
   assign hdr   = {DST_MAC, SRC_MAC,
                   etype_sel ? ETYPE_MHP : ETYPE_RAW};
   assign hsel  = 4'd13 - idx[3:0];
   assign rd    = AW'(idx - IW'(14));

   // Next-state and stream outputs, decoded from the current state.
   always_comb begin
      state_nxt    = state;
      close        = 1'b0;
      bus.o_wready = 1'b0;
      bus.o_tvalid = 1'b0;
      bus.o_tdata  = 8'h00;
      bus.o_tlast  = 1'b0;
      o_busy       = 1'b0;
      unique case (state)
         FILL: begin
            bus.o_wready = en && (count < CW'(BUF_DEPTH));
            if (acc && count == CW'(BUF_DEPTH - 1))
               close = 1'b1;
            else if (!acc && count != '0 &&
                     timer == 8'(IDLE_TIMEOUT - 1))
               close = 1'b1;
            if (close)
               state_nxt = HDR;
         end
         HDR: begin
            bus.o_tvalid = 1'b1;
            bus.o_tdata  = hdr[{hsel, 3'b000} +: 8];
            o_busy       = 1'b1;
            if (hs && idx == IW'(13))
               state_nxt = PAYLOAD;
         end
         PAYLOAD: begin
            bus.o_tvalid = 1'b1;
            bus.o_tdata  = mem[rd];
            bus.o_tlast  = last;
            o_busy       = 1'b1;
            if (hs && last)
               state_nxt = FILL;
            else if (hs && idx == cnt_x + IW'(13))
               state_nxt = PAD;
         end
         PAD: begin
            bus.o_tvalid = 1'b1;
            bus.o_tlast  = last;
            o_busy       = 1'b1;
            if (hs && last)
               state_nxt = FILL;
         end
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         state <= FILL;
      else
         state <= state_nxt;
   end

   // Fill count, idle timer, frame byte index and ethertype latch.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         en        <= 1'b0;
         count     <= '0;
         timer     <= '0;
         idx       <= '0;
         etype_sel <= 1'b0;
         sent      <= 1'b0;
      end else begin
         en   <= 1'b1;
         sent <= hs && last;
         if (close)
            etype_sel <= i_link;
         if (acc)
            count <= count + CW'(1);
         else if (hs && last)
            count <= '0;
         if (state == FILL && !acc && count != '0 && !close)
            timer <= timer + 8'd1;
         else
            timer <= '0;
         if (state == FILL)
            idx <= '0;
         else if (hs)
            idx <= last ? '0 : idx + IW'(1);
      end
   end

   // Payload store; contents are meaningless beyond count.
   always_ff @(posedge i_clk) begin
      if (acc)
         mem[count[AW-1:0]] <= bus.i_wdata;
   end

   assign o_frame_sent = sent;

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed bench for eth_frame_tx: frame contents, close timing,
// backpressure stability, full-buffer and mid-frame reset cases.
module tb_eth_frame_tx;

   logic clk;
   logic rst_n;
   logic link;
   logic busy;
   logic frame_sent;

   eth_frame_tx_if tif ();

   eth_frame_tx dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_link       (link),
      .bus          (tif),
      .o_busy       (busy),
      .o_frame_sent (frame_sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] rx [$];
   logic       rxl [$];
   logic [7:0] pl [$];
   logic [7:0] exp_q [$];

   int   stall_bad = 0;
   int   drop_bad  = 0;
   int   busy_bad  = 0;
   int   sent_bad  = 0;
   int   sent_cnt  = 0;
   logic in_frame  = 1'b0;
   logic prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic prev_last = 1'b0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Stream monitor: capture handshaken bytes, police stream rules.
   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame   = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall &&
             (!tif.o_tvalid || tif.o_tdata !== prev_data ||
              tif.o_tlast !== prev_last))
            stall_bad++;
         if (in_frame && !tif.o_tvalid)
            drop_bad++;
         if (tif.o_tvalid && tif.o_wready)
            busy_bad++;
         if (busy !== tif.o_tvalid)
            busy_bad++;
         if (frame_sent) begin
            sent_cnt++;
            if (tif.o_tvalid || !tif.o_wready)
               sent_bad++;
         end
         if (tif.o_tvalid && tif.i_tready) begin
            rx.push_back(tif.o_tdata);
            rxl.push_back(tif.o_tlast);
         end
         if (tif.o_tvalid)
            in_frame = !(tif.i_tready && tif.o_tlast);
         prev_stall = tif.o_tvalid && !tif.i_tready;
         prev_data  = tif.o_tdata;
         prev_last  = tif.o_tlast;
      end
   end

   task automatic push(input logic [7:0] b);
      tif.i_wdata  = b;
      tif.i_wvalid = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (tif.o_wready) begin
            @(posedge clk);
            #1;
            tif.i_wvalid = 1'b0;
            return;
         end
      end
      tif.i_wvalid = 1'b0;
      chk("push_timeout", 1, 0);
   endtask

   task automatic idle(input int n);
      tif.i_wvalid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Negedges seen with tvalid low before the first frame byte.
   task automatic wait_start(input string tag, input int exp_lat);
      int lat;
      lat = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tif.o_tvalid)
            break;
         lat++;
      end
      chk(tag, lat, exp_lat);
   endtask

   task automatic wait_sent(input string tag, input int n0);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (sent_cnt > n0) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!got)
         chk({tag, "_timeout"}, 1, 0);
      idle(3);
      chk({tag, "_pulses"}, sent_cnt - n0, 1);
   endtask

   task automatic build(input logic lk);
      exp_q.delete();
      repeat (6) exp_q.push_back(8'hFF);
      exp_q.push_back(8'h02);
      repeat (4) exp_q.push_back(8'h00);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h88);
      exp_q.push_back(lk ? 8'hB6 : 8'hB5);
      foreach (pl[i]) exp_q.push_back(pl[i]);
      while (exp_q.size() < 60) exp_q.push_back(8'h00);
   endtask

   task automatic check_frame(input string tag);
      int bad;
      int nl;
      int pos;
      int n;
      bad = 0;
      nl  = 0;
      pos = -1;
      n   = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
      chk({tag, "_len"}, rx.size(), exp_q.size());
      for (int i = 0; i < n; i++)
         if (rx[i] !== exp_q[i])
            bad++;
      chk({tag, "_bytes_bad"}, bad, 0);
      foreach (rxl[i])
         if (rxl[i]) begin
            nl++;
            pos = i;
         end
      chk({tag, "_tlast_n"}, nl, 1);
      chk({tag, "_tlast_pos"}, pos, exp_q.size() - 1);
      rx.delete();
      rxl.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_before_edge", tif.o_wready, 0);
      @(posedge clk);
      #1;
      chk("rdy_after_edge", tif.o_wready, 1);
   endtask

   initial begin
      int n0;
      rst_n        = 1'b0;
      link         = 1'b0;
      tif.i_wdata  = 8'h00;
      tif.i_wvalid = 1'b0;
      tif.i_tready = 1'b1;
      #2;
      chk("rst_tvalid", tif.o_tvalid, 0);
      chk("rst_tlast", tif.o_tlast, 0);
      chk("rst_tdata", tif.o_tdata, 0);
      chk("rst_wready", tif.o_wready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sent", frame_sent, 0);
      do_reset();

      // 1: three bytes, idle close, padded raw frame
      pl = '{8'hAA, 8'hBB, 8'hCC};
      n0 = sent_cnt;
      foreach (pl[i]) push(pl[i]);
      wait_start("t1_close_lat", 16);
      wait_sent("t1", n0);
      build(1'b0);
      check_frame("t1");

      // 2: full buffer closes at once, 65th byte waits
      pl.delete();
      n0 = sent_cnt;
      for (int i = 0; i < 64; i++) begin
         pl.push_back(8'(i));
         push(8'(i));
      end
      @(negedge clk);
      chk("t2_wready_full", tif.o_wready, 0);
      chk("t2_busy_full", busy, 1);
      push(8'h40);
      chk("t2_pulses", sent_cnt - n0, 1);
      build(1'b0);
      check_frame("t2a");
      pl = '{8'h40};
      n0 = sent_cnt;
      wait_start("t2b_close_lat", 16);
      wait_sent("t2b", n0);
      build(1'b0);
      check_frame("t2b");

      // 3: MHP ethertype latched, link toggles, random stalls
      link = 1'b1;
      pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      n0 = sent_cnt;
      foreach (pl[i]) push(pl[i]);
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         if (tif.o_tvalid) begin
            link = ~link;
            tif.i_tready = 1'($urandom_range(0, 1));
         end
         if (sent_cnt > n0)
            break;
      end
      tif.i_tready = 1'b1;
      link = 1'b0;
      chk("t3_pulses", sent_cnt - n0, 1);
      build(1'b1);
      check_frame("t3");
      chk("t3_stall_bad", stall_bad, 0);
      chk("t3_drop_bad", drop_bad, 0);

      // 4: second byte on the 16th idle cycle joins the frame
      pl = '{8'h5A, 8'hA5};
      n0 = sent_cnt;
      push(8'h5A);
      idle(15);
      push(8'hA5);
      wait_start("t4_close_lat", 16);
      wait_sent("t4", n0);
      build(1'b0);
      check_frame("t4");

      // 5: reset mid-payload aborts, next frame is clean
      rx.delete();
      rxl.delete();
      for (int i = 0; i < 30; i++) push(8'h80 + 8'(i));
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         #1;
         if (rx.size() >= 20)
            break;
      end
      chk("t5_reached_byte20", rx.size(), 20);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_tvalid", tif.o_tvalid, 0);
      chk("t5_rst_wready", tif.o_wready, 0);
      chk("t5_rst_busy", busy, 0);
      rx.delete();
      rxl.delete();
      do_reset();
      pl = '{8'h01};
      n0 = sent_cnt;
      push(8'h01);
      wait_start("t5_close_lat", 16);
      wait_sent("t5", n0);
      build(1'b0);
      check_frame("t5");

      // 6: 46 bytes need no pad, 45 need one pad byte
      pl.delete();
      n0 = sent_cnt;
      for (int i = 0; i < 46; i++) begin
         pl.push_back(8'(i + 1));
         push(8'(i + 1));
      end
      wait_sent("t6a", n0);
      build(1'b0);
      check_frame("t6a");
      pl.delete();
      n0 = sent_cnt;
      for (int i = 0; i < 45; i++) begin
         pl.push_back(8'(8'hC0 + i));
         push(8'(8'hC0 + i));
      end
      wait_sent("t6b", n0);
      build(1'b0);
      chk("t6b_pad_byte", exp_q[59], 0);
      check_frame("t6b");

      chk("stall_bad", stall_bad, 0);
      chk("drop_bad", drop_bad, 0);
      chk("busy_bad", busy_bad, 0);
      chk("sent_bad", sent_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/eth_frame_tx.md
Name: eth_frame_tx

Overview:
- Downstream stage of the task manager's Ethernet write side.
- Collects the MHP protocol byte stream (the wdata/wvalid/wready triple) into a store-and-forward buffer.
- On frame close it emits a complete Ethernet II frame to the MAC byte stream: header, payload, and zero padding to the 60-byte minimum.
- The ethertype is selected by the task manager's link flag.

Parameters:
DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC, sent MSB byte first
SRC_MAC, 48'h02_00_00_00_00_01, source MAC, sent MSB byte first
ETYPE_RAW, 16'h88B5, ethertype when link flag low
ETYPE_MHP, 16'h88B6, ethertype when link flag high
BUF_DEPTH, 64, payload buffer bytes (power of 2, 2..256)
IDLE_TIMEOUT, 16, idle cycles after the last accepted byte before the frame closes (1..255)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_link  in  1  ethertype select (1 = MHP)
i_wdata  in  8  payload byte from protocol
i_wvalid  in  1  payload byte valid
o_wready  out  1  payload byte accepted when i_wvalid && o_wready
o_tdata  out  8  frame byte to MAC
o_tvalid  out  1  frame byte valid
i_tready  in  1  MAC accepts byte when o_tvalid && i_tready
o_tlast  out  1  final byte of frame
o_busy  out  1  high in HDR/PAYLOAD/PAD
o_frame_sent  out  1  one-cycle pulse after the last byte handshake

Behaviour:
- One clock domain, i_clk.
- Reset: async assert on i_rst_n low. While in reset: o_tvalid=0, o_tlast=0, o_tdata=0, o_wready=0, o_busy=0, o_frame_sent=0; state=FILL; count=0; idle timer=0.
- o_wready goes 1 from the first clock edge after deassertion.
- FSM states: FILL -> HDR -> PAYLOAD -> PAD -> FILL.
- PAD is skipped when count >= 46.
- FILL:
  - o_wready=1 iff count < BUF_DEPTH. Each accepted byte is written at buf[count], and count increments.
  - Idle timer: cleared on every accept and whenever count=0; otherwise increments each cycle.
  - Close condition: count reaches BUF_DEPTH, or timer reaches IDLE_TIMEOUT with count > 0.
  - On close: latch i_link into etype_sel, drop o_wready the next cycle, go to HDR.
  - An accept on the same cycle the timer would expire wins: the byte is taken and the timer clears.
  - A full buffer closes the frame immediately after the BUF_DEPTH-th accept, with no timeout wait.
  - count=0 never closes.
- HDR: 14 bytes in order: DST_MAC[47:40]..[7:0], SRC_MAC likewise, then the selected ethertype [15:8], [7:0].
- PAYLOAD: buf[0]..buf[count-1] in order.
- PAD: 0x00 bytes until the payload plus pad totals 46, so the minimum frame is 60 bytes. No FCS is sent; the MAC appends it.
- Stream rules:
  - o_tvalid stays 1 continuously from the first header byte to the last frame byte.
  - o_tdata and o_tlast hold stable while o_tvalid && !i_tready.
  - A byte advances only on handshake.
  - o_tlast=1 only on the final byte.
  - First header byte is presented no later than 2 cycles after close.
  - Zero-stall throughput: 1 byte/cycle.
- After the final handshake:
  - o_tvalid=0 the next cycle.
  - o_frame_sent pulses for that cycle.
  - count clears and state returns to FILL; o_wready is 1 again that cycle.
- The latched etype_sel is immune to i_link changes during transmission.
- No payload is accepted while o_busy=1; upstream sees o_wready=0 and must hold its byte.
- Frame length = 14 + max(count, 46). Internal byte counter width covers up to 14 + BUF_DEPTH.
- Reset mid-frame aborts the frame: o_tvalid drops immediately (async); buffered data is discarded.

Test Plan:
1. i_link=0, push AA BB CC, then idle → after 16 idle cycles: 60-byte frame FF×6, 02 00 00 00 00 01, 88 B5, AA BB CC, 43×00; o_tlast only on byte 60; o_frame_sent pulses once.
2. Push 64 consecutive bytes 00..3F → o_wready low the cycle after the 64th accept; 78-byte frame with no pad, payload 00..3F, o_tlast on byte 78; the 65th byte is held by upstream and appears as byte 0 of the next frame.
3. i_link=1 at close, toggle i_link during transmission → ethertype bytes 88 B6; a random i_tready duty cycle (~50%) yields an identical byte sequence, with o_tdata/o_tlast stable during stalls and o_tvalid never dropping mid-frame.
4. Push one byte, then push a second exactly at idle cycle 16 → both bytes land in one frame (accept wins); the frame closes 16 cycles after the second byte.
5. Assert i_rst_n low during PAYLOAD byte 20 → o_tvalid=0 and o_wready=0 asynchronously; after release, push 01 and idle → a clean 60-byte frame containing only payload 01.
6. Push exactly 46 bytes → 60-byte frame with no PAD state; push 45 → one 00 pad byte, o_tlast on that pad byte.
